// File: rtl/six_gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : six_gate_pkg                                                    |
// | Purpose  : Shared constants and types for the six-gate test sequencer:    |
// |            gate width, error counter width, sequencer state encoding and   |
// |            the base stimulus table (cumulative walking-one).               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package six_gate_pkg;

  localparam int GATE_W  = 6;   // six gates per package
  localparam int ERR_W   = 8;   // saturating failure counter
  localparam int IDX_W   = 7;   // covers 7 base + 64 sweep vectors
  localparam int CNT_W   = 4;   // settle counter, SETTLE_CYCLES up to 15
  localparam int BASE_N  = 7;
  localparam int SWEEP_N = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Each entry turns on one more gate than the previous one.
  localparam logic [GATE_W-1:0] BASE_PAT [BASE_N] = '{
    6'h00, 6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F
  };

endpackage
`default_nettype wire

// File: rtl/six_gate_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : six_gate_pattern_gen                                            |
// | Purpose  : Maps a vector index to the 6-bit stimulus pattern and flags the |
// |            final vector of the run.                                        |
// | Ports    : i_index   - vector index (0 = first pattern)                    |
// |            o_pattern - stimulus for gate inputs A6..A1                     |
// |            o_last    - high when i_index is the final vector               |
// | Config   : SIX_GATE_TEST_EXHAUSTIVE_EN appends a 0x00..0x3F sweep after   |
// |            the 7 base patterns (71 vectors); otherwise 7 vectors.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module six_gate_pattern_gen
  import six_gate_pkg::*;
(
  input  logic [IDX_W-1:0]  i_index,
  output logic [GATE_W-1:0] o_pattern,
  output logic              o_last
);

  logic w_in_base;
  assign w_in_base = (i_index < IDX_W'(BASE_N));

`ifdef SIX_GATE_TEST_EXHAUSTIVE_EN
  // Sweep offset; for base indices this wraps to a large value and never
  // matches the final-sweep compare, so no extra qualification is needed.
  logic [IDX_W-1:0] w_sweep;
  assign w_sweep = i_index - IDX_W'(BASE_N);

  always_comb begin
    o_pattern = '0;
    if (w_in_base) begin
      o_pattern = BASE_PAT[i_index[2:0]];
    end else begin
      o_pattern = w_sweep[GATE_W-1:0];
    end
  end

  assign o_last = (w_sweep == IDX_W'(SWEEP_N - 1));
`else
  always_comb begin
    o_pattern = '0;
    if (w_in_base) begin
      o_pattern = BASE_PAT[i_index[2:0]];
    end
  end

  assign o_last = (i_index == IDX_W'(BASE_N - 1));
`endif

endmodule
`default_nettype wire

// File: rtl/six_gate_test_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : six_gate_test_sequencer                                         |
// | Purpose  : Self-test controller for a six-gate inverter/buffer model.      |
// |            Drives each stimulus vector, waits SETTLE_CYCLES, samples the   |
// |            gate outputs, and reports pass, error count and first failure.  |
// | Params   : SETTLE_CYCLES - hold cycles before sampling (1..15)             |
// |            INVERT        - 1: expect y = ~a, 0: expect y = a               |
// | Ports    : clk, rst          - clock, synchronous active-high reset        |
// |            i_start          - run request, honoured only in IDLE           |
// |            i_abort          - stop the run, no done pulse                  |
// |            i_y              - gate outputs Y6..Y1                          |
// |            o_a              - gate inputs A6..A1                           |
// |            o_busy           - high in DRIVE/SETTLE/CHECK                   |
// |            o_done           - one-cycle completion pulse                   |
// |            o_pass           - last completed run had zero errors          |
// |            o_err_count      - failing vectors, saturates at 255           |
// |            o_first_fail_pat - stimulus of the first failing vector        |
// |            o_first_fail_y   - outputs sampled at the first failure        |
// | Config   : SIX_GATE_TEST_EXHAUSTIVE_EN (in six_gate_pattern_gen) extends  |
// |            the run with a full 64-vector sweep.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module six_gate_test_sequencer
  import six_gate_pkg::*;
#(
  parameter int   SETTLE_CYCLES = 2,
  parameter logic INVERT        = 1'b1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [GATE_W-1:0] i_y,
  output logic [GATE_W-1:0] o_a,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [GATE_W-1:0] o_first_fail_pat,
  output logic [GATE_W-1:0] o_first_fail_y
);

  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [GATE_W-1:0]  r_a;
  logic               r_last;
  logic [IDX_W-1:0]   r_index;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic               r_pass;
  logic [ERR_W-1:0]   r_err_count;
  logic [GATE_W-1:0]  r_ff_pat;
  logic [GATE_W-1:0]  r_ff_y;

  logic [IDX_W-1:0]   w_gen_idx;
  logic [GATE_W-1:0]  w_pat;
  logic               w_pat_last;
  logic [GATE_W-1:0]  w_expect;
  logic               w_mismatch;

  logic               w_start_run;
  logic               w_enter_drive;
  logic               w_enter_done;
  logic               w_go_quiet;
  logic               w_do_check;

  // r_index always points at the next vector to drive; IDLE forces vector 0
  // so a run always begins at the start of the table.
  assign w_gen_idx = (r_state == ST_IDLE) ? '0 : r_index;

  six_gate_pattern_gen u_pattern_gen (
    .i_index   (w_gen_idx),
    .o_pattern (w_pat),
    .o_last    (w_pat_last)
  );

  assign w_expect   = INVERT ? ~r_a : r_a;
  assign w_mismatch = (i_y != w_expect);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (i_start) w_state_nxt = ST_DRIVE;
        ST_DRIVE:  w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (r_settle_cnt == C_SETTLE_LAST) w_state_nxt = ST_CHECK;
        ST_CHECK:  w_state_nxt = r_last ? ST_DONE : ST_DRIVE;
        ST_DONE:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    o_busy        = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) ||
                    (r_state == ST_CHECK);
    o_done        = (r_state == ST_DONE);
    w_start_run   = (r_state == ST_IDLE) && (w_state_nxt == ST_DRIVE);
    w_enter_drive = (w_state_nxt == ST_DRIVE);
    w_enter_done  = (w_state_nxt == ST_DONE);
    // Any exit from an active run (completion or abort) parks the inputs at 0.
    w_go_quiet    = (r_state != ST_IDLE) &&
                    ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE));
    // An abort landing on CHECK discards that vector's result.
    w_do_check    = (r_state == ST_CHECK) && (w_state_nxt != ST_IDLE);
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_last       <= 1'b0;
      r_index      <= '0;
      r_settle_cnt <= '0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_ff_pat     <= '0;
      r_ff_y       <= '0;
    end else begin
      // Stimulus changes only when a vector is launched or the run ends.
      if (w_enter_drive) begin
        r_a     <= w_pat;
        r_last  <= w_pat_last;
        r_index <= w_gen_idx + IDX_W'(1);
      end else if (w_go_quiet) begin
        r_a     <= '0;
        r_last  <= 1'b0;
        r_index <= '0;
      end

      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
      end else begin
        r_settle_cnt <= '0;
      end

      if (w_start_run) begin
        r_err_count <= '0;
        r_ff_pat    <= '0;
        r_ff_y      <= '0;
      end else if (w_do_check && w_mismatch) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
        // Counter is cleared at start and never wraps, so zero means this is
        // the first failure of the run.
        if (r_err_count == '0) begin
          r_ff_pat <= r_a;
          r_ff_y   <= i_y;
        end
      end

      // Include the final vector's result so pass is valid alongside done.
      if (w_enter_done) begin
        r_pass <= (r_err_count == '0) && !w_mismatch;
      end
    end
  end

  assign o_a              = r_a;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_fail_pat = r_ff_pat;
  assign o_first_fail_y   = r_ff_y;

endmodule
`default_nettype wire

// File: tb/tb_six_gate_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_six_gate_test_sequencer                                      |
// | Purpose  : Directed self-checking bench. Two sequencers: u_dut_a expects   |
// |            an inverter (INVERT=1) facing an inverter model with an         |
// |            optional stuck-at-1 mask; u_dut_b expects a buffer (INVERT=0)   |
// |            facing a plain inverter model.                                  |
// | Config   : SIX_GATE_TEST_EXHAUSTIVE_EN selects the 71-vector expectations. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_six_gate_test_sequencer;

`ifdef SIX_GATE_TEST_EXHAUSTIVE_EN
  localparam int N_VEC     = 71;
  localparam int STUCK_ERR = 36;  // 4 base + 32 sweep vectors with a[2]=1
  localparam int INV0_ERR  = 71;
`else
  localparam int N_VEC     = 7;
  localparam int STUCK_ERR = 4;
  localparam int INV0_ERR  = 7;
`endif
  localparam int SETTLE   = 2;
  localparam int PER      = 2 + SETTLE;
  localparam int DONE_CYC = 1 + N_VEC * PER;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [5:0] stuck = 6'h00;
  logic [5:0] y_a, y_b, a_a, a_b, ffp_a, ffp_b, ffy_a, ffy_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] err_a, err_b;

  // Chip models: ideal inverters, one with stuck-at-1 outputs.
  assign y_a = ~a_a | stuck;
  assign y_b = ~a_b;

  six_gate_test_sequencer #(.SETTLE_CYCLES(SETTLE), .INVERT(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_abort(abort_a), .i_y(y_a),
    .o_a(a_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_err_count(err_a), .o_first_fail_pat(ffp_a), .o_first_fail_y(ffy_a)
  );

  six_gate_test_sequencer #(.SETTLE_CYCLES(SETTLE), .INVERT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_abort(abort_b), .i_y(y_b),
    .o_a(a_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_err_count(err_b), .o_first_fail_pat(ffp_b), .o_first_fail_y(ffy_b)
  );

  // Selected-DUT view so one run task serves both instances.
  logic       sel_b = 1'b0;
  logic [5:0] m_a, m_ffp, m_ffy;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_err;
  assign m_a    = sel_b ? a_b    : a_a;
  assign m_busy = sel_b ? busy_b : busy_a;
  assign m_done = sel_b ? done_b : done_a;
  assign m_pass = sel_b ? pass_b : pass_a;
  assign m_err  = sel_b ? err_b  : err_a;
  assign m_ffp  = sel_b ? ffp_b  : ffp_a;
  assign m_ffy  = sel_b ? ffy_b  : ffy_a;

  int n_done_a = 0;
  int n_done_b = 0;
  always @(negedge clk) begin
    if (done_a) n_done_a++;
    if (done_b) n_done_b++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    start_a = v && !sel_b;
    start_b = v && sel_b;
  endtask

  function automatic logic [5:0] exp_pat(input int k);
    case (k)
      0:       return 6'h00;
      1:       return 6'h01;
      2:       return 6'h03;
      3:       return 6'h07;
      4:       return 6'h0F;
      5:       return 6'h1F;
      6:       return 6'h3F;
      default: return 6'(k - 7);
    endcase
  endfunction

  // Start a run on the selected DUT and follow it to done (bounded).
  task automatic run_seq(input string tag, input bit chk_pats, input bit poke);
    int cyc;
    int gap;
    int d0;
    d0 = sel_b ? n_done_b : n_done_a;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    cyc = 1;
    gap = 0;
    check_eq({tag, "_busy_c1"}, 32'(m_busy), 32'd1);
    while (!m_done && cyc < DONE_CYC + 20) begin
      if (chk_pats && ((cyc - 1) % PER) == 0)
        check_eq($sformatf("%s_a_vec%0d", tag, (cyc - 1) / PER), 32'(m_a),
                 32'(exp_pat((cyc - 1) / PER)));
      if (!m_busy) gap++;
      if (poke && (cyc == 5 || cyc == 13)) set_start(1'b1);
      tick();
      set_start(1'b0);
      cyc++;
    end
    check_eq({tag, "_done_cyc"}, 32'(cyc), 32'(DONE_CYC));
    check_eq({tag, "_busy_gap"}, 32'(gap), 32'd0);
    check_eq({tag, "_busy_in_done"}, 32'(m_busy), 32'd0);
    check_eq({tag, "_a_in_done"}, 32'(m_a), 32'd0);
    if (poke) set_start(1'b1);  // start in the DONE cycle must be ignored
    tick();
    set_start(1'b0);
    check_eq({tag, "_idle_busy"}, 32'(m_busy), 32'd0);
    check_eq({tag, "_done_pulses"},
             32'((sel_b ? n_done_b : n_done_a) - d0), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_a"},    32'(a_a),    32'd0);
    check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
    check_eq({tag, "_done"}, 32'(done_a), 32'd0);
    check_eq({tag, "_pass"}, 32'(pass_a), 32'd0);
    check_eq({tag, "_err"},  32'(err_a),  32'd0);
    check_eq({tag, "_ffp"},  32'(ffp_a),  32'd0);
    check_eq({tag, "_ffy"},  32'(ffy_a),  32'd0);
  endtask

  initial begin
    int cyc;
    int d0;

    repeat (3) tick();
    check_reset_a("rst");
    rst = 1'b0;
    tick();

    // Fault-free inverter.
    run_seq("clean", 1'b1, 1'b0);
    check_eq("clean_pass", 32'(pass_a), 32'd1);
    check_eq("clean_err",  32'(err_a),  32'd0);

    // Y3 stuck at 1.
    stuck = 6'h04;
    run_seq("stuck", 1'b0, 1'b0);
    check_eq("stuck_pass", 32'(pass_a), 32'd0);
    check_eq("stuck_err",  32'(err_a),  32'(STUCK_ERR));
    check_eq("stuck_ffp",  32'(ffp_a),  32'h07);
    check_eq("stuck_ffy",  32'(ffy_a),  32'h3C);
    stuck = 6'h00;

    // Buffer expectation against an inverter: every vector fails.
    sel_b = 1'b1;
    run_seq("inv0", 1'b0, 1'b0);
    check_eq("inv0_pass", 32'(pass_b), 32'd0);
    check_eq("inv0_err",  32'(err_b),  32'(INV0_ERR));
    check_eq("inv0_ffp",  32'(ffp_b),  32'h00);
    check_eq("inv0_ffy",  32'(ffy_b),  32'h3F);
    sel_b = 1'b0;

    // Abort during the third vector's SETTLE (cycle 10).
    d0 = n_done_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq("abort_pre_a",    32'(a_a),    32'h03);
    check_eq("abort_pre_busy", 32'(busy_a), 32'd1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    check_eq("abort_a",    32'(a_a),    32'd0);
    check_eq("abort_err",  32'(err_a),  32'd0);
    check_eq("abort_pass", 32'(pass_a), 32'd0);
    repeat (40) tick();
    check_eq("abort_no_done", 32'(n_done_a - d0), 32'd0);

    run_seq("after_abort", 1'b0, 1'b0);
    check_eq("after_abort_pass", 32'(pass_a), 32'd1);

    // start pulses while busy and in the DONE cycle are ignored.
    run_seq("poke", 1'b0, 1'b1);
    check_eq("poke_pass", 32'(pass_a), 32'd1);

    // rst during the third vector's CHECK (cycle 12) with Y1 stuck at 1.
    stuck = 6'h01;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (cyc < 12) begin
      tick();
      cyc++;
    end
    check_eq("midrst_pre_err", 32'(err_a), 32'd1);
    check_eq("midrst_pre_ffp", 32'(ffp_a), 32'h01);
    check_eq("midrst_pre_ffy", 32'(ffy_a), 32'h3F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_a("midrst");
    d0 = n_done_a;
    repeat (40) tick();
    check_eq("midrst_no_done", 32'(n_done_a - d0), 32'd0);
    stuck = 6'h00;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/six_gate_test_sequencer.md
# six_gate_test_sequencer

Self-test controller for the six-channel 74LS04-style inverter models (and the non-inverting six-gate parts) in the 74LSXX library. It applies a fixed sequence of 6-bit stimulus patterns to the gate inputs and waits a programmable settle time. It then samples the gate outputs, checks them against the expected function, and reports pass/fail, an error count and the first failing vector. It sits between a board-level start/status interface and one instance of a six-gate chip model.

## Interface
- SETTLE_CYCLES, 2, cycles to hold each pattern before sampling; legal range 1..15
- INVERT, 1, expected function: 1 means y = ~a (74LS04), 0 means y = a (buffer parts)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run the sequence; ignored unless in IDLE
- abort  in  1  synchronous stop; highest priority after rst
- y  in  6  gate outputs Y6..Y1 from the chip model
- a  out  6  gate inputs A6..A1 driven to the chip model
- busy  out  1  high from DRIVE through CHECK
- done  out  1  one-cycle pulse on completion (not on abort)
- pass  out  1  level; 1 when the last completed run had zero errors
- err_count  out  8  number of failing patterns; saturates at 255
- first_fail_pat  out  6  pattern of the first failure in the run
- first_fail_y  out  6  y sampled at the first failure

## Operation
- Reset values: a=0, busy=0, done=0, pass=0, err_count=0, first_fail_pat=0, first_fail_y=0, state IDLE, index 0.
- Base sequence, 7 patterns, applied in this order: 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F (cumulative walking-one).
- States:
  - IDLE: a=0. On start, clear err_count and the first_fail registers, set index to 0, and go to DRIVE.
  - DRIVE: a <= pattern[index], go to SETTLE.
  - SETTLE: hold a for SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK: compare y with the expected value (~a if INVERT, else a). On mismatch, increment err_count (saturating). If it is the first mismatch of the run, latch first_fail_pat=a and first_fail_y=y. If the last pattern is done, go to DONE; otherwise increment index and go to DRIVE.
  - DONE: pulse done, set pass = (err_count==0), a <= 0, go to IDLE.
- Errors are counted per pattern, not per bit.
- abort in any non-IDLE state: go to IDLE, a=0, busy=0. No done pulse. pass and err_count keep the values of the partial run.
- start while busy, or in the DONE cycle, is ignored.
- rst mid-run returns every output to its reset value on the next edge.

## Timing
- Per pattern: 1 DRIVE cycle + SETTLE_CYCLES + 1 CHECK cycle.
- With start sampled at cycle 0, done is high at cycle 1 + N·(2+SETTLE_CYCLES), where N is the pattern count.
- busy rises at cycle 1 and falls in the done cycle.
- a changes only on DRIVE entry and on DONE/abort/rst.
- y is sampled only in CHECK. The chip model's propagation delay must be shorter than SETTLE_CYCLES clock periods.

## Configuration
- SIX_GATE_TEST_EXHAUSTIVE_EN defined: after the base 7 patterns, run an exhaustive sweep 0x00..0x3F, giving N=71. err_count saturation applies.
- Not defined: base sequence only, N=7. No sweep counter logic is generated.

## Structure
- Shared package six_gate_pkg holds:
  - GATE_W=6
  - the state enum (IDLE, DRIVE, SETTLE, CHECK, DONE)
  - the base pattern constant array
  - ERR_W=8
- Sub-module six_gate_pattern_gen: index in, pattern and last flag out, with the exhaustive extension under the macro. The sequencer module holds the FSM, settle counter, compare and status registers.

## Test plan
- Fault-free inverter model, INVERT=1, SETTLE_CYCLES=2, macro off; start pulsed at cycle 0. Required: done at cycle 29, pass=1, err_count=0, a returns to 0x00.
- Y3 (y[2]) stuck at 1. Required: 4 failures (0x07, 0x0F, 0x1F, 0x3F), err_count=4, pass=0, first_fail_pat=0x07, first_fail_y=0x3C.
- INVERT=0 against the inverter model. Required: all 7 patterns fail, err_count=7, first_fail_pat=0x00, first_fail_y=0x3F.
- abort asserted during the third pattern's SETTLE. Required: next cycle busy=0 and a=0, no done pulse. A new start then runs the full sequence cleanly.
- rst asserted mid-CHECK. Required: all outputs at reset values next cycle. start pulses while busy are ignored, so busy stays continuous and done occurs exactly once.
- Macro on, fault-free model, SETTLE_CYCLES=2. Required: a steps through the 7 base patterns then 0x00..0x3F, done at cycle 285, pass=1.
